// File: rtl/pulse_period_meter.sv
// rtl/pulse_period_meter.sv - measures clk cycles between rising edges of a slow asynchronous signal
// Optional glitch filter between synchroniser and edge detector: define PERIOD_METER_FILTER_EN.
module pulse_period_meter #(
    parameter int CNT_W          = 26,
    parameter int EXP_PERIOD     = 2_500_000,
    parameter int TOL            = 16,
    parameter int TIMEOUT_CYCLES = 50_000_000
`ifdef PERIOD_METER_FILTER_EN
    ,
    parameter int FILT_LEN       = 4
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             in_range,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W:0]   EXP_EXT     = (CNT_W+1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]   TOL_EXT     = (CNT_W+1)'(TOL);

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             delay_q, delay_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             in_range_q, in_range_d;
    logic             timeout_q, timeout_d;

    logic             level;
    logic             edge_det;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W:0]   cnt_ext;
    logic [CNT_W:0]   diff;

`ifdef PERIOD_METER_FILTER_EN
    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;

    // Filtered level flips only after FILT_LEN consecutive sync2 samples disagree with it
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        if (sync2_q == filt_q) begin
            fcnt_d = '0;
        end else if (fcnt_q == FW'(FILT_LEN - 1)) begin
            filt_d = sync2_q;
            fcnt_d = '0;
        end else begin
            fcnt_d = fcnt_q + FW'(1);
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    assign edge_det = level & ~delay_q;

    // Next-state logic: synchroniser, saturating counter, FSM and output registers
    always_comb begin
        sync1_d    = sig_in;
        sync2_d    = sync1_q;
        delay_d    = level;
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        in_range_d = in_range_q;
        timeout_d  = timeout_q;

        // Edge restarts the interval at 1 so period equals cycles between edges
        if (edge_det)
            cnt_next = CNT_W'(1);
        else if (cnt_q == TIMEOUT_VAL)
            cnt_next = cnt_q;
        else
            cnt_next = cnt_q + CNT_W'(1);

        // Deviation computed one bit wider so the subtraction never wraps
        cnt_ext = {1'b0, cnt_q};
        diff    = (cnt_ext >= EXP_EXT) ? (cnt_ext - EXP_EXT) : (EXP_EXT - cnt_ext);

        if (!enable) begin
            state_d   = IDLE;
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = WAIT_FIRST;
                end
                WAIT_FIRST: begin
                    cnt_d = cnt_next;
                    if (edge_det)
                        state_d = MEASURE;
                    else if (cnt_q == TIMEOUT_VAL)
                        timeout_d = 1'b1;
                end
                MEASURE: begin
                    cnt_d = cnt_next;
                    if (edge_det) begin
                        period_d   = cnt_q;
                        valid_d    = 1'b1;
                        in_range_d = (diff <= TOL_EXT);
                        timeout_d  = 1'b0;
                    end else if (cnt_q == TIMEOUT_VAL) begin
                        timeout_d = 1'b1;
                        state_d   = WAIT_FIRST;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // All state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            delay_q    <= 1'b0;
            cnt_q      <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            in_range_q <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef PERIOD_METER_FILTER_EN
            filt_q     <= 1'b0;
            fcnt_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            delay_q    <= delay_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            in_range_q <= in_range_d;
            timeout_q  <= timeout_d;
`ifdef PERIOD_METER_FILTER_EN
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
`endif
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign in_range     = in_range_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// tb/tb_pulse_period_meter.sv - scoreboard bench for pulse_period_meter
module tb_pulse_period_meter;

    localparam int CNT_W = 10;
`ifdef PERIOD_METER_FILTER_EN
    localparam int FILT_LEN = 4;
    localparam int LAT      = 3 + FILT_LEN;
`else
    localparam int LAT      = 3;
`endif

    logic             clk;
    logic             reset;
    logic             enable;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             in_range;
    logic             timeout;

    typedef struct packed {
        int cyc;
        int per;
        bit inr;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_vec;
    int   n_bad;
    int   b;

    pulse_period_meter #(
        .CNT_W          (CNT_W),
        .EXP_PERIOD     (100),
        .TOL            (2),
        .TIMEOUT_CYCLES (300)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sig_in       (sig_in),
        .period       (period),
        .period_valid (period_valid),
        .in_range     (in_range),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int per, input bit inr);
        exp_t e;
        e.cyc = cyc + LAT;
        e.per = per;
        e.inr = inr;
        q.push_back(e);
    endtask

    // Rise now, stay high for half the gap, low for the rest; the strobe expectation refers to the interval ending here
    task automatic rise_then(input int gap, input bit strobe, input int per, input bit inr);
        sig_in = 1'b1;
        if (strobe) push(per, inr);
        repeat (gap / 2) @(negedge clk);
        sig_in = 1'b0;
        repeat (gap - gap / 2) @(negedge clk);
    endtask

    // Monitor: every strobe must match the head of the expectation queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (period_valid === 1'b1) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_strobe: got strobe with period %0d at cycle %0d, expected none", period, cyc);
                end else begin
                    e = q.pop_front();
                    check("strobe_cycle", cyc, e.cyc);
                    check("period", 32'(period), e.per);
                    check("in_range", 32'(in_range), 32'(e.inr));
                    check("timeout_at_strobe", 32'(timeout), 0);
                end
            end
        end
    end

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        reset  = 1'b0;
        enable = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_period", 32'(period), 0);
        check("reset_valid", 32'(period_valid), 0);
        check("reset_in_range", 32'(in_range), 0);
        check("reset_timeout", 32'(timeout), 0);
        reset  = 1'b1;
        enable = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_timeout", 32'(timeout), 0);

        // nominal period 100: first edge only arms
        rise_then(100, 1'b0, 0, 1'b0);
        repeat (4) rise_then(100, 1'b1, 100, 1'b1);

        // 103, 97, 98 around the tolerance window
        rise_then(103, 1'b1, 100, 1'b1);
        rise_then(97, 1'b1, 103, 1'b0);
        rise_then(98, 1'b1, 97, 1'b0);
        rise_then(100, 1'b1, 98, 1'b1);

        // stop the input and wait for the timeout
        sig_in = 1'b1;
        push(100, 1'b1);
        b = cyc;
        repeat (50) @(negedge clk);
        sig_in = 1'b0;
        while (cyc < b + LAT + 299) @(negedge clk);
        check("timeout_before_limit", 32'(timeout), 0);
        @(negedge clk);
        check("timeout_at_limit", 32'(timeout), 1);
        check("period_hold_timeout", 32'(period), 100);
        check("in_range_hold_timeout", 32'(in_range), 1);
        repeat (30) @(negedge clk);
        check("timeout_sticky", 32'(timeout), 1);
        rise_then(100, 1'b0, 0, 1'b0);
        check("timeout_after_rearm", 32'(timeout), 1);
        rise_then(100, 1'b1, 100, 1'b1);
        check("timeout_cleared", 32'(timeout), 0);

        // enable drop for 50 cycles
        enable = 1'b0;
        @(negedge clk);
        check("disabled_timeout", 32'(timeout), 0);
        repeat (49) @(negedge clk);
        check("disabled_timeout_late", 32'(timeout), 0);
        check("disabled_period_hold", 32'(period), 100);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        rise_then(100, 1'b0, 0, 1'b0);
        rise_then(100, 1'b1, 100, 1'b1);

        // asynchronous reset with counter around 60
        sig_in = 1'b1;
        push(100, 1'b1);
        repeat (50) @(negedge clk);
        sig_in = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset_period", 32'(period), 0);
        check("midreset_valid", 32'(period_valid), 0);
        check("midreset_in_range", 32'(in_range), 0);
        check("midreset_timeout", 32'(timeout), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        rise_then(100, 1'b0, 0, 1'b0);
        rise_then(100, 1'b1, 100, 1'b1);

        // 2-cycle glitch 60 cycles into a period-100 wave
        sig_in = 1'b1;
        push(100, 1'b1);
        repeat (50) @(negedge clk);
        sig_in = 1'b0;
        repeat (10) @(negedge clk);
        sig_in = 1'b1;
`ifndef PERIOD_METER_FILTER_EN
        push(60, 1'b0);
`endif
        repeat (2) @(negedge clk);
        sig_in = 1'b0;
        repeat (38) @(negedge clk);
`ifdef PERIOD_METER_FILTER_EN
        rise_then(300, 1'b1, 100, 1'b1);
`else
        rise_then(300, 1'b1, 40, 1'b0);
`endif

        // edge coincident with counter at the timeout limit is a measurement
        rise_then(100, 1'b1, 300, 1'b0);
        check("no_timeout_at_limit_edge", 32'(timeout), 0);
        rise_then(100, 1'b1, 100, 1'b1);

        repeat (20) @(negedge clk);
        check("pending_expectations", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
Receive-side checker for slow tick/clock signals produced by the team's clock dividers, such as the 1 Hz source.
- Synchronises an incoming slow square wave into the clk domain.
- Measures the number of clk cycles between consecutive rising edges.
- Reports each period with a valid strobe, an in-range flag against an expected period, and a timeout flag when edges stop.
- Used on the board and in benches to prove divider output frequency.

Parameters:
CNT_W, 26, width of the period counter and the period output.
EXP_PERIOD, 2_500_000, expected period in clk cycles.
TOL, 16, allowed absolute deviation from EXP_PERIOD, in cycles.
TIMEOUT_CYCLES, 50_000_000, cycles with no rising edge before timeout; must be < 2^CNT_W.
FILT_LEN, 4, glitch-filter depth; used only with the optional feature.

Ports:
clk  input  1  system clock, 50 MHz.
reset  input  1  asynchronous, active-low reset.
enable  input  1  measurement enable, synchronous to clk.
sig_in  input  1  slow signal under test, asynchronous to clk.
period  output  CNT_W  last measured period in clk cycles.
period_valid  output  1  one-cycle strobe when period updates.
in_range  output  1  |period - EXP_PERIOD| <= TOL; updated with period.
timeout  output  1  sticky flag: no edge for TIMEOUT_CYCLES.

Behaviour:
- Reset values (reset low): period=0, period_valid=0, in_range=0, timeout=0. Also cleared by reset: state=IDLE, counter=0, sync flops=0.
- Input path: sig_in → 2-FF synchroniser → delay flop.
  - edge_det = sync2 & ~delay.
  - edge_det is high 3 clk edges after sig_in rises: sync2 at edge 2, edge_det in that cycle, consumed at edge 3.
- Counter: on every cycle with edge_det=1, counter<=1; otherwise counter<=counter+1.
  - Counter saturates at TIMEOUT_CYCLES; never wraps.
- FSM states:
  - IDLE: counter held at 0, no outputs change. enable=1 → WAIT_FIRST.
  - WAIT_FIRST: first edge_det → MEASURE. No period reported (first interval is undefined). Timeout is checked here as well.
  - MEASURE: on edge_det, at the same clk edge:
    - period <= counter, so period = cycles between the two detected edges.
    - period_valid <= 1 for exactly one cycle.
    - in_range <= (|counter - EXP_PERIOD| <= TOL), computed at CNT_W+1 bits, no wrap.
    - timeout <= 0.
    - Stay in MEASURE.
- Timeout, in WAIT_FIRST or MEASURE: counter reaches TIMEOUT_CYCLES with no edge →
  - timeout <= 1;
  - state → WAIT_FIRST;
  - period and in_range hold their last values.
- Timeout is sticky until the next reported period, an enable deassert, or reset.
  - The first edge after a timeout only re-arms (→ MEASURE) and does not clear timeout.
  - timeout clears at the following edge, together with its period_valid.
- enable=0 in any state → IDLE next cycle.
  - counter <= 0 and timeout <= 0.
  - period and in_range hold.
  - An edge in the same cycle as enable=0 is ignored.
- Edge coincident with counter==TIMEOUT_CYCLES: the edge wins, and it is treated as a normal measurement (period=TIMEOUT_CYCLES), no timeout.
- Period shorter than 2 cycles is impossible because of the synchroniser. period=1 cannot occur.
- Async reset mid-measurement aborts immediately. Output is restored to reset values, and no strobe is produced.

Optional Feature:
PERIOD_METER_FILTER_EN
- Defined: a glitch filter sits between sync2 and the edge detector.
  - The filtered level changes only after FILT_LEN consecutive identical sync2 samples.
  - Pulses shorter than FILT_LEN cycles are ignored.
  - Edge latency rises to 3+FILT_LEN cycles.
  - Measured periods are unchanged for clean inputs.
- Undefined: no filter; edge_det is taken directly from sync2/delay.

Test Plan:
(Sim overrides: EXP_PERIOD=100, TOL=2, TIMEOUT_CYCLES=300, CNT_W=10.)
1. reset low, then high; enable=1; square wave with period 100 clk → first edge gives no strobe; each later edge gives period=100, in_range=1, period_valid high for 1 cycle, 3 cycles after the sig_in rise.
2. Period 103, then 97, then 98 → period=103 in_range=0; period=97 in_range=0; period=98 in_range=1.
3. Stop sig_in after valid measurements → timeout=1 exactly 300 cycles after the last edge, period holds 100. Restart at period 100 → first edge no strobe, timeout stays 1; second edge gives period=100 and timeout=0.
4. Drop enable mid-period, hold 50 cycles, raise it again → no strobe and timeout=0 while disabled; first edge after re-enable re-arms only; next edge gives period=100.
5. Assert reset mid-period (counter ~60) → all outputs 0 immediately; after release, behaviour is as in test 1.
6. With PERIOD_METER_FILTER_EN: 2-cycle glitch inside a period-100 wave → ignored, period stays 100. Without the macro: the glitch produces a short period (e.g. 40) with in_range=0.
